// File: rtl/filter_line_pp_if.sv
// Pixel stream bundle between source, filter engine and packer.
// Carries the raw input stream and the filtered output stream with row/frame markers.
// Signal suffixes are from the filter engine's point of view (slave modport).
//   in_val_i / in_rdy_o / in_dat_i          raw pixel stream into the engine
//   out_val_o / out_rdy_i / out_dat_o       filtered pixel stream out of the engine
//   out_sol_o / out_eof_o / out_type_o      start-of-row, end-of-frame, filter type per beat
interface filter_line_pp_if #(
    parameter int CH = 4
);
    logic              in_val_i;
    logic              in_rdy_o;
    logic [8*CH-1:0]   in_dat_i;
    logic              out_val_o;
    logic              out_rdy_i;
    logic [8*CH-1:0]   out_dat_o;
    logic              out_sol_o;
    logic              out_eof_o;
    logic [2:0]        out_type_o;

    // Filter engine side.
    modport slave (
        input  in_val_i, in_dat_i, out_rdy_i,
        output in_rdy_o, out_val_o, out_dat_o, out_sol_o, out_eof_o, out_type_o
    );

    // Pixel source / packer side.
    modport master (
        output in_val_i, in_dat_i, out_rdy_i,
        input  in_rdy_o, out_val_o, out_dat_o, out_sol_o, out_eof_o, out_type_o
    );
endinterface

// File: rtl/filter_line_pp.sv
// PNG scanline filter engine (None/Sub/Up/Average/Paeth per frame) with an internal line buffer.
// Latency: pixel accepted at edge N appears on out_val_o after edge N+2; 1 pixel/cycle sustained.
// Backpressure: out_val_o && !out_rdy_i freezes the whole pipeline and drops in_rdy_o.
// Ports: clk, rst (sync, active high); cfg_w_i/cfg_h_i/cfg_mode_i sampled on accepted start_i;
//        busy_o spans accepted start through the done_o cycle; done_o pulses once per frame;
//        px_if carries raw input and filtered output streams (see filter_line_pp_if).
module filter_line_pp #(
    parameter int CH    = 4,
    parameter int W_MAX = 1024,
    parameter int W_WD  = 11,
    parameter int H_WD  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_WD-1:0]   cfg_w_i,
    input  logic [H_WD-1:0]   cfg_h_i,
    input  logic [2:0]        cfg_mode_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    filter_line_pp_if.slave   px_if
);
    localparam int DW = 8 * CH;
    localparam int CW = W_WD + H_WD;
    localparam int AW = (W_MAX > 1) ? $clog2(W_MAX) : 1;
    localparam logic [W_WD-1:0] X_ONE = 1;
    localparam logic [H_WD-1:0] Y_ONE = 1;
    localparam logic [CW-1:0]   C_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic              busy_q, done_q;
    logic [W_WD-1:0]   w_q, x_q;
    logic [H_WD-1:0]   h_q, y_q;
    logic [2:0]        mode_q;
    logic [CW-1:0]     total_q, in_cnt_q;

    // S0: accepted raw pixel; its above-row value lands in rd_q on the same edge.
    logic              s0_vld_q, s0_x0_q, s0_y0_q, s0_eof_q;
    logic [DW-1:0]     s0_raw_q;
    logic [DW-1:0]     rd_q;

    // S1: current pixel plus the previous pixel's raw/above values (a and c sources).
    logic              s1_vld_q, s1_x0_q, s1_y0_q, s1_eof_q;
    logic [DW-1:0]     s1_raw_q, s1_above_q, s1_prev_raw_q, s1_prev_above_q;

    logic              out_val_q, out_sol_q, out_eof_q;
    logic [DW-1:0]     out_dat_q;
    logic [2:0]        out_type_q;

    logic [DW-1:0]     line_mem [W_MAX];

    logic              adv, in_rdy, in_acc, last_fire;
    logic [DW-1:0]     filt_dat;
    logic [AW-1:0]     addr;

    // One enable for every stage: the pipeline only moves when the output slot frees up.
    assign adv       = !out_val_q || px_if.out_rdy_i;
    assign in_rdy    = (state_q == RUN) && (in_cnt_q < total_q) && adv;
    assign in_acc    = px_if.in_val_i && in_rdy;
    assign last_fire = out_val_q && px_if.out_rdy_i && out_eof_q;
    assign addr      = x_q[AW-1:0];

    function automatic logic [7:0] filt_byte(input logic [2:0] m, input logic [7:0] r,
                                             input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
        logic [8:0]         sum;
        logic signed [10:0] p, pa, pb, pc;
        logic [7:0]         pred;
        sum = {1'b0, a} + {1'b0, b};
        p   = $signed({3'b000, a}) + $signed({3'b000, b}) - $signed({3'b000, c});
        pa  = p - $signed({3'b000, a});
        pb  = p - $signed({3'b000, b});
        pc  = p - $signed({3'b000, c});
        if (pa < 0) pa = -pa;
        if (pb < 0) pb = -pb;
        if (pc < 0) pc = -pc;
        if (pa <= pb && pa <= pc) pred = a;
        else if (pb <= pc)        pred = b;
        else                      pred = c;
        case (m)
            3'd1:    filt_byte = r - a;
            3'd2:    filt_byte = r - b;
            3'd3:    filt_byte = r - 8'(sum >> 1);
            3'd4:    filt_byte = r - pred;
            default: filt_byte = r;
        endcase
    endfunction

    always_comb begin
        filt_dat = '0;
        for (int k = 0; k < CH; k++) begin
            logic [7:0] a, b, c;
            a = s1_x0_q ? 8'd0 : s1_prev_raw_q[8*k +: 8];
            b = s1_y0_q ? 8'd0 : s1_above_q[8*k +: 8];
            c = (s1_x0_q || s1_y0_q) ? 8'd0 : s1_prev_above_q[8*k +: 8];
            filt_dat[8*k +: 8] = filt_byte(mode_q, s1_raw_q[8*k +: 8], a, b, c);
        end
    end

    // Line buffer: read-before-write at the accepted pixel's column; no reset on contents.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            rd_q          <= line_mem[addr];
            line_mem[addr] <= px_if.in_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            w_q             <= '0;
            h_q             <= '0;
            mode_q          <= '0;
            total_q         <= '0;
            in_cnt_q        <= '0;
            x_q             <= '0;
            y_q             <= '0;
            s0_vld_q        <= 1'b0;
            s0_x0_q         <= 1'b0;
            s0_y0_q         <= 1'b0;
            s0_eof_q        <= 1'b0;
            s0_raw_q        <= '0;
            s1_vld_q        <= 1'b0;
            s1_x0_q         <= 1'b0;
            s1_y0_q         <= 1'b0;
            s1_eof_q        <= 1'b0;
            s1_raw_q        <= '0;
            s1_above_q      <= '0;
            s1_prev_raw_q   <= '0;
            s1_prev_above_q <= '0;
            out_val_q       <= 1'b0;
            out_sol_q       <= 1'b0;
            out_eof_q       <= 1'b0;
            out_dat_q       <= '0;
            out_type_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        w_q      <= cfg_w_i;
                        h_q      <= cfg_h_i;
                        mode_q   <= (cfg_mode_i > 3'd4) ? 3'd0 : cfg_mode_i;
                        total_q  <= CW'(cfg_w_i) * CW'(cfg_h_i);
                        in_cnt_q <= '0;
                        x_q      <= '0;
                        y_q      <= '0;
                        busy_q   <= 1'b1;
                        if (cfg_w_i == '0 || cfg_h_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (last_fire) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (in_acc) begin
                in_cnt_q <= in_cnt_q + C_ONE;
                if (x_q == w_q - X_ONE) begin
                    x_q <= '0;
                    y_q <= y_q + Y_ONE;
                end else begin
                    x_q <= x_q + X_ONE;
                end
            end

            if (adv) begin
                s0_vld_q <= in_acc;
                if (in_acc) begin
                    s0_raw_q <= px_if.in_dat_i;
                    s0_x0_q  <= (x_q == '0);
                    s0_y0_q  <= (y_q == '0);
                    s0_eof_q <= (x_q == w_q - X_ONE) && (y_q == h_q - Y_ONE);
                end

                // Previous-pixel registers only shift on real pixels, so bubbles never
                // break the x-1 relationship within a row.
                s1_vld_q <= s0_vld_q;
                if (s0_vld_q) begin
                    s1_raw_q        <= s0_raw_q;
                    s1_above_q      <= rd_q;
                    s1_prev_raw_q   <= s1_raw_q;
                    s1_prev_above_q <= s1_above_q;
                    s1_x0_q         <= s0_x0_q;
                    s1_y0_q         <= s0_y0_q;
                    s1_eof_q        <= s0_eof_q;
                end

                out_val_q <= s1_vld_q;
                if (s1_vld_q) begin
                    out_dat_q  <= filt_dat;
                    out_sol_q  <= s1_x0_q;
                    out_eof_q  <= s1_eof_q;
                    out_type_q <= mode_q;
                end
            end
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign px_if.in_rdy_o   = in_rdy;
    assign px_if.out_val_o  = out_val_q;
    assign px_if.out_dat_o  = out_dat_q;
    assign px_if.out_sol_o  = out_sol_q;
    assign px_if.out_eof_o  = out_eof_q;
    assign px_if.out_type_o = out_type_q;
endmodule

// File: tb/tb_filter_line_pp.sv
module tb_filter_line_pp;
    localparam int CH   = 3;
    localparam int DW   = 8 * CH;
    localparam int W_WD = 11;
    localparam int H_WD = 11;
    localparam int BUDGET = 4000;

    logic              clk = 1'b0;
    logic              rst;
    logic [W_WD-1:0]   cfg_w_i;
    logic [H_WD-1:0]   cfg_h_i;
    logic [2:0]        cfg_mode_i;
    logic              start_i;
    logic              busy_o, done_o;

    filter_line_pp_if #(.CH(CH)) px_if ();

    filter_line_pp #(.CH(CH), .W_MAX(1024), .W_WD(W_WD), .H_WD(H_WD)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_w_i    (cfg_w_i),
        .cfg_h_i    (cfg_h_i),
        .cfg_mode_i (cfg_mode_i),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .px_if      (px_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] pix_q[$];
    logic [DW-1:0] got_dat[$];
    bit            got_sol[$];
    bit            got_eof[$];
    logic [2:0]    got_type[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: PNG filter rules applied directly to the whole raw image.
    function automatic logic [7:0] ref_byte(input int mode, input int r, input int a,
                                            input int b, input int c);
        int p, pa, pb, pc, pred;
        case (mode)
            1: pred = a;
            2: pred = b;
            3: pred = (a + b) / 2;
            4: begin
                p  = a + b - c;
                pa = (p > a) ? p - a : a - p;
                pb = (p > b) ? p - b : b - p;
                pc = (p > c) ? p - c : c - p;
                if (pa <= pb && pa <= pc) pred = a;
                else if (pb <= pc)        pred = b;
                else                      pred = c;
            end
            default: pred = 0;
        endcase
        return 8'(r - pred);
    endfunction

    function automatic logic [DW-1:0] ref_pix(input int i, input int w, input int mode);
        logic [DW-1:0] res;
        int x, y, r, a, b, c;
        x = i % w;
        y = i / w;
        res = '0;
        for (int k = 0; k < CH; k++) begin
            r = int'(pix_q[i][8*k +: 8]);
            a = (x > 0) ? int'(pix_q[i-1][8*k +: 8]) : 0;
            b = (y > 0) ? int'(pix_q[i-w][8*k +: 8]) : 0;
            c = (x > 0 && y > 0) ? int'(pix_q[i-w-1][8*k +: 8]) : 0;
            res[8*k +: 8] = ref_byte(mode, r, a, b, c);
        end
        return res;
    endfunction

    task automatic fill_rand(input int n);
        pix_q = {};
        for (int i = 0; i < n; i++) pix_q.push_back(DW'($urandom));
    endtask

    // Directed values go into byte 0; the other lanes carry random bytes.
    task automatic load_b0(input int v[$]);
        pix_q = {};
        foreach (v[i]) pix_q.push_back({16'($urandom), 8'(v[i])});
    endtask

    task automatic check_b0(input string tag, input int v[$]);
        check({tag, "_count"}, 64'(got_dat.size()), 64'(v.size()));
        foreach (v[i])
            if (i < got_dat.size()) check(tag, 64'(got_dat[i][7:0]), 64'(v[i]));
    endtask

    task automatic run_frame(input int w, input int h, input int mode, input int rdy_pct,
                             input bit poke_start);
        int  n, pi, cyc, eff;
        bit  finished, acc, prev_stall;
        logic [DW-1:0] prev_dat;
        n = w * h; pi = 0; cyc = 0; finished = 0; prev_stall = 0; prev_dat = '0;
        eff = (mode > 4) ? 0 : mode;
        got_dat = {}; got_sol = {}; got_eof = {}; got_type = {};

        @(negedge clk);
        cfg_w_i = W_WD'(w); cfg_h_i = H_WD'(h); cfg_mode_i = 3'(mode); start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cfg_w_i = W_WD'($urandom_range(1, 9)); cfg_h_i = H_WD'($urandom_range(1, 9));
        cfg_mode_i = 3'($urandom);
        check("busy_after_start", 64'(busy_o), 64'd1);

        while (!finished && cyc < BUDGET) begin
            if (done_o) begin
                finished = 1;
                check("busy_in_done", 64'(busy_o), 64'd1);
            end else begin
                px_if.out_rdy_i = ($urandom_range(99) < rdy_pct);
                if (!px_if.in_val_i && pi < n) px_if.in_val_i = ($urandom_range(3) != 0);
                px_if.in_dat_i = (pi < n) ? pix_q[pi] : '0;
                start_i = poke_start && (cyc == 4);
                #1;
                if (prev_stall) begin
                    check("stall_hold_val", 64'(px_if.out_val_o), 64'd1);
                    check("stall_hold_dat", 64'(px_if.out_dat_o), 64'(prev_dat));
                end
                acc = px_if.in_val_i && px_if.in_rdy_o;
                if (acc) pi++;
                if (px_if.out_val_o && px_if.out_rdy_i) begin
                    got_dat.push_back(px_if.out_dat_o);
                    got_sol.push_back(px_if.out_sol_o);
                    got_eof.push_back(px_if.out_eof_o);
                    got_type.push_back(px_if.out_type_o);
                end
                prev_stall = px_if.out_val_o && !px_if.out_rdy_i;
                prev_dat   = px_if.out_dat_o;
                @(negedge clk);
                if (acc) px_if.in_val_i = 1'b0;
                cyc++;
            end
        end
        start_i = 1'b0;
        px_if.in_val_i = 1'b0;
        check("frame_done_seen", 64'(finished), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done_o), 64'd0);
        check("idle_after_done", 64'(busy_o), 64'd0);

        check("beat_count", 64'(got_dat.size()), 64'(n));
        for (int i = 0; i < n && i < got_dat.size(); i++) begin
            check("beat_dat", 64'(got_dat[i]), 64'(ref_pix(i, w, eff)));
            check("beat_sol", 64'(got_sol[i]), 64'((i % w) == 0));
            check("beat_eof", 64'(got_eof[i]), 64'(i == n - 1));
            check("beat_type", 64'(got_type[i]), 64'(eff));
        end
    endtask

    initial begin
        int v[$];
        int seen_bad;
        rst = 1'b1;
        start_i = 1'b0; cfg_w_i = '0; cfg_h_i = '0; cfg_mode_i = '0;
        px_if.in_val_i = 1'b0; px_if.in_dat_i = '0; px_if.out_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_in_rdy", 64'(px_if.in_rdy_o), 64'd0);
        check("rst_out_val", 64'(px_if.out_val_o), 64'd0);
        check("rst_sol", 64'(px_if.out_sol_o), 64'd0);
        check("rst_eof", 64'(px_if.out_eof_o), 64'd0);
        check("rst_dat", 64'(px_if.out_dat_o), 64'd0);
        check("rst_type", 64'(px_if.out_type_o), 64'd0);
        rst = 1'b0;

        // None, 3x2: data passes through, sol at beats 0/3, eof at beat 5.
        v = {10, 20, 30, 40, 50, 60};
        load_b0(v);
        run_frame(3, 2, 0, 100, 0);
        check_b0("none_b0", v);
        if (got_sol.size() == 6) begin
            check("none_sol3", 64'(got_sol[3]), 64'd1);
            check("none_eof5", 64'(got_eof[5]), 64'd1);
        end

        // Sub, 4x1.
        v = {5, 7, 10, 250};
        load_b0(v);
        run_frame(4, 1, 1, 100, 0);
        v = {5, 2, 3, 240};
        check_b0("sub_b0", v);
        if (got_type.size() > 0) check("sub_type", 64'(got_type[0]), 64'd1);

        // Up, 2x2: row 1 subtracts the buffered row 0.
        v = {1, 2, 5, 9};
        load_b0(v);
        run_frame(2, 2, 2, 100, 0);
        v = {1, 2, 4, 7};
        check_b0("up_b0", v);

        // Paeth, 2x2.
        v = {10, 20, 30, 25};
        load_b0(v);
        run_frame(2, 2, 4, 100, 0);
        v = {10, 10, 20, 251};
        check_b0("paeth_b0", v);

        // Average, 2x1, full pixels.
        pix_q = {24'h01FF01, 24'hFF01FF};
        run_frame(2, 1, 3, 100, 0);
        if (got_dat.size() == 2) begin
            check("avg_px0", 64'(got_dat[0]), 64'h01FF01);
            check("avg_px1", 64'(got_dat[1]), 64'hFF82FF);
        end

        // Random images, 50% output ready, every mode code including 5..7.
        for (int m = 0; m < 8; m++) begin
            fill_rand(17 * 5);
            run_frame(17, 5, m, 50, m == 4);
        end

        // Degenerate geometries.
        fill_rand(4);
        run_frame(1, 4, 4, 70, 0);
        fill_rand(5);
        run_frame(5, 1, 4, 70, 0);
        pix_q = {};
        run_frame(0, 3, 1, 100, 0);

        // Reset in the middle of a row: frame aborts with no done and no output.
        @(negedge clk);
        cfg_w_i = 17; cfg_h_i = 5; cfg_mode_i = 4; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        px_if.out_rdy_i = 1'b0;
        px_if.in_val_i = 1'b1;
        repeat (9) begin
            px_if.in_dat_i = DW'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_out_val", 64'(px_if.out_val_o), 64'd0);
        seen_bad = 0;
        px_if.out_rdy_i = 1'b1;
        repeat (30) begin
            #1;
            if (done_o || px_if.out_val_o || px_if.in_rdy_o) seen_bad++;
            @(negedge clk);
        end
        px_if.in_val_i = 1'b0;
        check("abort_quiet", 64'(seen_bad), 64'd0);

        fill_rand(17 * 5);
        run_frame(17, 5, 3, 50, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
